// File: rtl/mem_arbiter.sv
// Sequences one single-port, fixed-latency memory between instruction fetch and load/store.
// Data wins ties; a bounded data run while fetch waits guarantees fetch progress.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 2,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int WAIT_W = $clog2(LATENCY + 1);
  localparam int RUN_W  = $clog2(MAX_DATA_RUN + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LATENCY);
  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_DATA_RUN);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1: load/store owns the access
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                busy_q, busy_d;

  logic any_req;
  logic grant_dm;

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + RUN_W'(1);
  endfunction

  assign any_req  = if_req | dm_req;
  assign grant_dm = dm_req & (~if_req | (run_cnt_q < RUN_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // mem_we is held with mem_addr/mem_wdata so the capture decision in WAIT can reuse it.
  always_comb begin
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    run_cnt_d   = run_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (grant_dm) begin
          owner_d     = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          run_cnt_d   = if_req ? run_sat_inc(run_cnt_q) : '0;
        end else if (if_req) begin
          owner_d    = 1'b0;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          run_cnt_d  = '0;
        end
      end
      S_ISSUE: wait_cnt_d = WAIT_W'(1);
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_LAST) begin
          if (!mem_we_q) begin
            if (owner_q) dm_rdata_d = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          dm_done_d = owner_q;
          if_done_d = ~owner_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= 1'b0;
      wait_cnt_q  <= '0;
      run_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      run_cnt_q   <= run_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = busy_q;

endmodule
